apb_bridge_n: RTL
=================

APB_BRIDGE_N -- requirements
Module: apb_bridge_n

Interface
REQ-001 SHALL have parameter AW, default 8: address width (bits).
REQ-002 SHALL have parameter DW, default 32: data width (bits).
REQ-003 SHALL have parameter NSLV, default 4: slave count; power of 2, 2..16; slave index = paddr[AW-1 -: log2(NSLV)].
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16: ACCESS-cycle limit (used only under APB_TIMEOUT_EN).
REQ-005 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  host request valid.
- req_ready  out  1  bridge accepts request.
- req_addr  in  AW  request address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DW  read data (0 for writes).
- rsp_err  out  1  slave error or timeout.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  APB access phase.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- prdata  in  NSLV*DW  slave read data, slave i at bits [i*DW +: DW].
- pready  in  NSLV  per-slave ready.
- pslverr  in  NSLV  per-slave error.

Function
REQ-006 SHALL implement FSM IDLE, SETUP, ACCESS; req_ready = 1 only in IDLE.
REQ-007 SHALL, in IDLE with req_valid=1, register req_addr/req_write/req_wdata into paddr/pwrite/pwdata and go to SETUP.
REQ-008 SHALL, in SETUP, drive psel[idx]=1, other psel bits 0, penable=0, and go to ACCESS unconditionally.
REQ-009 SHALL, in ACCESS, drive psel[idx]=1, penable=1, and remain until pready[idx]=1.
REQ-010 SHALL sample only pready[idx], pslverr[idx] and the prdata slice idx; all other slaves' inputs are ignored.
REQ-011 SHALL, on the ACCESS cycle with pready[idx]=1, return to IDLE and on the next cycle assert rsp_valid=1 for exactly one cycle, with rsp_err=pslverr[idx] and rsp_rdata=prdata slice (read) or 0 (write).
REQ-012 SHALL hold paddr, pwrite and pwdata stable from SETUP through the final ACCESS cycle; in IDLE they keep their last values, with psel=0 and penable=0.
REQ-013 SHALL give a zero-wait transfer latency of 3 cycles: accept at T, SETUP at T+1, ACCESS at T+2, rsp_valid and req_ready both 1 at T+3; a new request accepted at T+3 gives back-to-back transfers.
REQ-014 SHALL hold rsp_rdata and rsp_err stable until the next rsp_valid.

Reset
REQ-015 SHALL, on rst=1, asynchronously force state=IDLE and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err to 0; req_ready=1 while rst=1.
REQ-016 SHALL abort any in-flight transfer on reset with no rsp_valid, and accept a new request on the first clk edge after rst falls.

Configuration
REQ-017 SHALL, when APB_TIMEOUT_EN is defined, count ACCESS cycles (counter cleared in SETUP); on the TIMEOUT_CYC-th ACCESS cycle with pready[idx]=0, end the transfer: IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-018 SHALL, when APB_TIMEOUT_EN is undefined, contain no counter and wait in ACCESS indefinitely.
REQ-019 SHALL give pready[idx]=1 on the TIMEOUT_CYC-th cycle priority over the timeout, so the transfer completes normally.

Verification
REQ-020 SHALL cover a zero-wait write: addr=0x40, wdata=0xFFFFFFFF, pready=all 1 -> psel=4'b0010, pwrite=1, rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
REQ-021 SHALL cover a read with 2 wait states: addr=0xC0, slave 3 prdata=0xA5A5_0001 -> penable high for 3 cycles, rsp_rdata=0xA5A5_0001 at T+5.
REQ-022 SHALL cover a slave error: addr=0x80, pslverr[2]=1 with pready[2]=1 -> rsp_err=1; pslverr[1]=1 during this transfer has no effect.
REQ-023 SHALL cover a mid-transfer reset: rst=1 during ACCESS -> psel=0 and penable=0 immediately, no rsp_valid, and the next request completes normally.
REQ-024 SHALL cover a timeout with APB_TIMEOUT_EN: pready held 0 -> rsp_valid with rsp_err=1 exactly 16 ACCESS cycles after penable rises; without the macro, the bridge stays in ACCESS for more than 100 cycles.
REQ-025 SHALL cover back-to-back transfers: req_valid held for addresses 0x00, 0x41, 0x82, 0xC3 -> four transfers at 3-cycle spacing, psel walking 0001, 0010, 0100, 1000.

Source files
------------

// File: rtl/apb_bridge_n.sv
// Host-request to APB bridge with NSLV slaves decoded from the top address bits.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_bridge_n #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int NSLV        = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW-1:0]      req_addr,
  input  logic               req_write,
  input  logic [DW-1:0]      req_wdata,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [NSLV-1:0]    psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr
);

  localparam int SW = $clog2(NSLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   paddr_q;
  logic            pwrite_q;
  logic [DW-1:0]   pwdata_q;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            load_req;

  logic [SW-1:0]   idx;
  logic [NSLV-1:0] sel_onehot;
  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;
  logic            timeout_hit;

  // Only the addressed slave's handshake and data are ever looked at.
  assign idx        = paddr_q[AW-1 -: SW];
  assign sel_onehot = NSLV'(1) << idx;
  assign sel_ready  = pready[idx];
  assign sel_err    = pslverr[idx];
  assign sel_rdata  = prdata[idx*DW +: DW];

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && cnt_q != TW'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed ACCESS cycles, so this flags the TIMEOUT_CYC-th one.
  assign timeout_hit = (state_q == ACCESS) && (cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    load_req    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_req = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins over a timeout landing on the same cycle.
        if (sel_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (load_req) begin
        paddr_q  <= req_addr;
        pwrite_q <= req_write;
        pwdata_q <= req_wdata;
      end
    end
  end

  // Select and enable decode straight from state so reset drops them at once.
  assign req_ready = (state_q == IDLE);
  assign psel      = (state_q == IDLE) ? '0 : sel_onehot;
  assign penable   = (state_q == ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
